// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-side memory responder:
// MMIO register offsets, register reset values and the address region select.
package dmem_pkg;

  localparam logic [3:0] OFF_MTIME    = 4'h0;
  localparam logic [3:0] OFF_MTIMECMP = 4'h4;
  localparam logic [3:0] OFF_STATUS   = 4'h8;
  localparam logic [3:0] OFF_GPIO     = 4'hC;

  localparam logic [31:0] RST_MTIME    = 32'h0000_0000;
  localparam logic [31:0] RST_MTIMECMP = 32'hFFFF_FFFF;
  localparam logic [31:0] RST_STATUS   = 32'h0000_0000;
  localparam logic [31:0] RST_GPIO     = 32'h0000_0000;

  typedef enum logic [1:0] {
    REG_RAM      = 2'd0,
    REG_MMIO     = 2'd1,
    REG_UNMAPPED = 2'd2
  } region_e;

endpackage

// File: rtl/mmio_timer.sv
// Free-running MTIME counter, MTIMECMP compare register and the sticky
// match flag exposed as STATUS bit 0.
module mmio_timer
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr_en,
  input  logic [3:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_mtime,
  output logic [31:0] o_mtimecmp,
  output logic        o_irq
);

  logic [31:0] r_mtime;
  logic [31:0] r_mtimecmp;
  logic        r_irq;
  logic        w_match;
  logic        w_clr;

  assign w_match = (r_mtime == r_mtimecmp);
  assign w_clr   = i_wr_en && (i_off == OFF_STATUS) && i_wdata[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mtime    <= RST_MTIME;
      r_mtimecmp <= RST_MTIMECMP;
      r_irq      <= RST_STATUS[0];
    end else begin
      // A store to MTIME overrides this cycle's increment.
      if (i_wr_en && (i_off == OFF_MTIME))
        r_mtime <= i_wdata;
      else
        r_mtime <= r_mtime + 32'd1;

      if (i_wr_en && (i_off == OFF_MTIMECMP))
        r_mtimecmp <= i_wdata;

      // A match in the same cycle as a W1C wins over the clear.
      r_irq <= w_match | (r_irq & ~w_clr);
    end
  end

  assign o_mtime    = r_mtime;
  assign o_mtimecmp = r_mtimecmp;
  assign o_irq      = r_irq;

endmodule

// File: rtl/data_mem_resp.sv
// Data-side responder for the single-cycle core: word RAM plus a small
// timer/GPIO register bank, combinational reads and edge-committed stores.
module data_mem_resp
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000,
  parameter int          GPIO_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic [31:0]       wrt_data,
  input  logic              mem_wrt,
  output logic [31:0]       rd_data,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq,
  output logic              bus_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  logic [31:0]       r_ram [DEPTH_WORDS];
  logic [GPIO_W-1:0] r_gpio;
  logic              r_bus_err;

  region_e     w_region;
  logic [AW-1:0] w_idx;
  logic [3:0]  w_off;
  logic        w_mmio_wr;
  logic [31:0] w_mtime;
  logic [31:0] w_mtimecmp;
  logic        w_irq;

  assign w_idx     = addr[AW+1:2];
  assign w_off     = {addr[3:2], 2'b00};
  assign w_mmio_wr = mem_wrt && (w_region == REG_MMIO);

  always_comb begin
    w_region = REG_UNMAPPED;
    if (addr < RAM_BYTES)
      w_region = REG_RAM;
    else if (addr[31:4] == MMIO_BASE[31:4])
      w_region = REG_MMIO;
  end

  // RAM is never cleared; gating on rst drops a store issued while in reset.
  always_ff @(posedge clk) begin
    if (rst && mem_wrt && (w_region == REG_RAM))
      r_ram[w_idx] <= wrt_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gpio    <= RST_GPIO[GPIO_W-1:0];
      r_bus_err <= 1'b0;
    end else begin
      if (w_mmio_wr && (w_off == OFF_GPIO))
        r_gpio <= wrt_data[GPIO_W-1:0];
      if (mem_wrt && (w_region == REG_UNMAPPED))
        r_bus_err <= 1'b1;
    end
  end

  mmio_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_mmio_wr),
    .i_off      (w_off),
    .i_wdata    (wrt_data),
    .o_mtime    (w_mtime),
    .o_mtimecmp (w_mtimecmp),
    .o_irq      (w_irq)
  );

  always_comb begin
    rd_data = 32'h0;
    case (w_region)
      REG_RAM:  rd_data = r_ram[w_idx];
      REG_MMIO: begin
        case (w_off)
          OFF_MTIME:    rd_data = w_mtime;
          OFF_MTIMECMP: rd_data = w_mtimecmp;
          OFF_STATUS:   rd_data = {31'h0, w_irq};
          OFF_GPIO:     rd_data = 32'(r_gpio);
          default:      rd_data = 32'h0;
        endcase
      end
      default:  rd_data = 32'h0;
    endcase
  end

  assign gpio_out  = r_gpio;
  assign timer_irq = w_irq;
  assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: directed vector table, hand-written
// timer/reset sequences and a randomized run against a behavioural model.
module tb_data_mem_resp;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          GW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   wrt_data = '0;
  logic          mem_wrt = 1'b0;
  logic [31:0]   rd_data;
  logic [GW-1:0] gpio_out;
  logic          timer_irq;
  logic          bus_err;

  data_mem_resp #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE), .GPIO_W(GW)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wrt_data  (wrt_data),
    .mem_wrt   (mem_wrt),
    .rd_data   (rd_data),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [31:0]   m_mem [DEPTH];
  bit            m_vld [DEPTH];
  logic [31:0]   m_mtime;
  logic [31:0]   m_cmp;
  bit            m_irq;
  bit            m_berr;
  logic [GW-1:0] m_gpio;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    bit          w;
    bit          chk;
    logic [31:0] rd;
  } vec_t;

  vec_t tv [24];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_mtime = 32'h0;
    m_cmp   = 32'hFFFF_FFFF;
    m_irq   = 1'b0;
    m_berr  = 1'b0;
    m_gpio  = '0;
  endfunction

  function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
    v = 32'h0;
    if (a < DEPTH * 4) begin
      v = m_mem[a / 4];
      return m_vld[a / 4];
    end
    if (a >= BASE && a < BASE + 16) begin
      case ((a - BASE) / 4)
        0: v = m_mtime;
        1: v = m_cmp;
        2: v = {31'h0, m_irq};
        3: v = 32'(m_gpio);
        default: v = 32'h0;
      endcase
    end
    return 1'b1;
  endfunction

  // One bus cycle: drive, check rd_data before the edge, advance the model, check registered outputs.
  // mode: 0 no rd check, 1 rd against exp_rd, 2 rd against model.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input bit w,
                      input int mode, input logic [31:0] exp_rd, input string nm);
    logic [31:0]   mv;
    bit            def;
    bit            in_ram;
    bit            in_mmio;
    int            off;
    logic [31:0]   n_mtime;
    logic [31:0]   n_cmpv;
    bit            n_irq;
    bit            n_berr;
    logic [GW-1:0] n_gpio;
    addr = a; wrt_data = d; mem_wrt = w;
    #1;
    def = model_read(a, mv);
    if (mode == 1) check($sformatf("%s rd", nm), rd_data, exp_rd);
    else if (mode == 2 && def) check($sformatf("%s rd", nm), rd_data, mv);
    in_ram  = (a < DEPTH * 4);
    in_mmio = !in_ram && (a >= BASE) && (a < BASE + 16);
    off     = in_mmio ? int'((a - BASE) / 4) : -1;
    n_mtime = (w && off == 0) ? d : m_mtime + 32'd1;
    n_cmpv  = (w && off == 1) ? d : m_cmp;
    n_irq   = (m_mtime == m_cmp) || (m_irq && !(w && off == 2 && d[0]));
    n_gpio  = (w && off == 3) ? d[GW-1:0] : m_gpio;
    n_berr  = m_berr || (w && !in_ram && !in_mmio);
    @(posedge clk);
    if (w && in_ram) begin
      m_mem[a / 4] = d;
      m_vld[a / 4] = 1'b1;
    end
    m_mtime = n_mtime; m_cmp = n_cmpv; m_irq = n_irq; m_gpio = n_gpio; m_berr = n_berr;
    #1;
    check($sformatf("%s gpio", nm), 32'(gpio_out), 32'(m_gpio));
    check($sformatf("%s irq", nm), 32'(timer_irq), 32'(m_irq));
    check($sformatf("%s berr", nm), 32'(bus_err), 32'(m_berr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    bit          w;
    int          r;

    tv[0]  = '{32'h0000_2000, 32'h0, 1'b0, 1'b1, 32'h0};
    tv[1]  = '{32'h0000_2000, 32'h0, 1'b0, 1'b1, 32'h0};
    tv[2]  = '{32'h0000_2000, 32'h0, 1'b0, 1'b1, 32'h0};
    tv[3]  = '{32'h0000_2000, 32'h0, 1'b0, 1'b1, 32'h0};
    tv[4]  = '{32'h0000_2000, 32'h0, 1'b0, 1'b1, 32'h0};
    tv[5]  = '{BASE,          32'h0, 1'b0, 1'b1, 32'd5};
    tv[6]  = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0};
    tv[7]  = '{32'h0000_0010, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF};
    tv[8]  = '{32'h0000_0013, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF};
    tv[9]  = '{32'h0000_0014, 32'h1111_1111, 1'b1, 1'b0, 32'h0};
    tv[10] = '{32'h0000_0014, 32'h2222_2222, 1'b1, 1'b1, 32'h1111_1111};
    tv[11] = '{32'h0000_0014, 32'h0, 1'b0, 1'b1, 32'h2222_2222};
    tv[12] = '{BASE,          32'hFFFF_FFFE, 1'b1, 1'b1, 32'd12};
    tv[13] = '{BASE,          32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE};
    tv[14] = '{BASE,          32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF};
    tv[15] = '{BASE,          32'h0, 1'b0, 1'b1, 32'h0};
    tv[16] = '{BASE,          32'h0, 1'b0, 1'b1, 32'h1};
    tv[17] = '{BASE + 8,      32'h0, 1'b0, 1'b1, 32'h1};
    tv[18] = '{BASE + 8,      32'h1, 1'b1, 1'b1, 32'h1};
    tv[19] = '{BASE + 8,      32'h0, 1'b0, 1'b1, 32'h0};
    tv[20] = '{BASE + 12,     32'h1A5, 1'b1, 1'b0, 32'h0};
    tv[21] = '{BASE + 12,     32'h0, 1'b0, 1'b1, 32'h0000_00A5};
    tv[22] = '{32'h0000_2000, 32'h0, 1'b1, 1'b1, 32'h0};
    tv[23] = '{BASE + 8,      32'h0, 1'b1, 1'b1, 32'h0};

    // Reset state
    model_reset();
    #12;
    addr = BASE + 4; #1;
    check("rst mtimecmp", rd_data, 32'hFFFF_FFFF);
    addr = BASE; #1;
    check("rst mtime", rd_data, 32'h0);
    addr = BASE + 8; #1;
    check("rst status", rd_data, 32'h0);
    check("rst gpio", 32'(gpio_out), 32'h0);
    check("rst irq", 32'(timer_irq), 32'h0);
    check("rst berr", 32'(bus_err), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 24; i++)
      step(tv[i].a, tv[i].d, tv[i].w, tv[i].chk ? 1 : 0, tv[i].rd, $sformatf("vec%0d", i));
    check("tbl gpio", 32'(gpio_out), 32'h0000_00A5);
    check("tbl berr", 32'(bus_err), 32'h1);
    check("tbl irq", 32'(timer_irq), 32'h0);

    // Match: MTIMECMP=20, MTIME=10 -> flag 11 edges after the MTIME store
    step(BASE + 4, 32'd20, 1'b1, 0, 32'h0, "cmp20");
    step(BASE, 32'd10, 1'b1, 1, 32'd10, "mt10");
    check("match pre", 32'(timer_irq), 32'h0);
    for (int i = 1; i <= 10; i++) begin
      step(BASE, 32'h0, 1'b0, 1, 32'(9 + i), $sformatf("cnt%0d", i));
      check($sformatf("match wait%0d", i), 32'(timer_irq), 32'h0);
    end
    step(BASE, 32'h0, 1'b0, 1, 32'd20, "hit");
    check("match rise", 32'(timer_irq), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(BASE, 32'h0, 1'b0, 0, 32'h0, "hold");
      check($sformatf("match hold%0d", i), 32'(timer_irq), 32'h1);
    end
    step(BASE + 8, 32'h1, 1'b1, 1, 32'h1, "w1c");
    check("w1c clear", 32'(timer_irq), 32'h0);

    // Clear issued in the match cycle must lose to the set
    step(BASE, 32'd18, 1'b1, 0, 32'h0, "mt18");
    step(BASE, 32'h0, 1'b0, 1, 32'd18, "c18");
    step(BASE, 32'h0, 1'b0, 1, 32'd19, "c19");
    step(BASE + 8, 32'h1, 1'b1, 1, 32'h0, "w1c_hit");
    check("set over clr", 32'(timer_irq), 32'h1);
    step(BASE + 8, 32'h0, 1'b1, 1, 32'h1, "w0_status");
    check("w0 no effect", 32'(timer_irq), 32'h1);

    // Asynchronous reset mid-cycle with a store pending
    addr = BASE + 12; wrt_data = 32'h55; mem_wrt = 1'b1;
    rst = 1'b0; #1;
    check("arst gpio", 32'(gpio_out), 32'h0);
    check("arst irq", 32'(timer_irq), 32'h0);
    check("arst berr", 32'(bus_err), 32'h0);
    check("arst rd gpio", rd_data, 32'h0);
    addr = BASE + 4; #1;
    check("arst rd cmp", rd_data, 32'hFFFF_FFFF);
    addr = 32'h10; wrt_data = 32'h1234_5678;
    @(posedge clk); #1;
    check("arst ram kept", rd_data, 32'hDEAD_BEEF);
    check("arst gpio hold", 32'(gpio_out), 32'h0);
    mem_wrt = 1'b0;
    model_reset();
    rst = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      d = $urandom;
      w = ($urandom_range(0, 9) < 4);
      if (r <= 4) begin
        a = ($urandom_range(0, 3) == 0) ? 32'(DEPTH * 4 - 4) + $urandom_range(0, 3)
                                        : 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      end else if (r <= 7) begin
        a = BASE + 32'($urandom_range(0, 3) * 4 + $urandom_range(0, 3));
      end else if (r == 8) begin
        case ($urandom_range(0, 3))
          0: a = 32'(DEPTH * 4);
          1: a = BASE + 16;
          2: a = BASE - 4;
          default: a = 32'h8000_0000 | $urandom;
        endcase
        w = ($urandom_range(0, 7) == 0);
      end else begin
        a = BASE + 4;
        d = m_mtime + 32'($urandom_range(1, 6));
        w = 1'b1;
      end
      step(a, d, w, 2, 32'h0, $sformatf("rnd%0d", i));
    end

    mem_wrt = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
